ifetch_unit: RTL and testbench

Instruction fetch stage for the MiniSys-1A CPU, sitting directly upstream of the instruction decoder. Generates sequential word PCs, issues requests to instruction memory through a req/gnt/rvalid handshake, and buffers returned words in a small in-order prefetch FIFO. Presents one instruction plus its PC to the decoder under a valid/ready handshake. Handles control-flow redirects from branch/jump/exception logic by flushing the FIFO and discarding in-flight responses.

---
 rtl/minisys_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 46 ++++
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// Shared MiniSys-1A definitions: instruction width, NOP encoding, PC stepping and the
// {pc, instruction} record carried by the fetch prefetch buffer.
package minisys_pkg;

    localparam int unsigned        INST_W           = 32;
    localparam logic [INST_W-1:0]  NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0]        PC_INC           = 32'd4;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// In-order show-ahead prefetch buffer of {pc, instruction}; flush wins over a same-cycle push.
module ifetch_fifo
    import minisys_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    input  logic                    flush,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          pop_en;

    assign pop_en = pop && (count_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop_en);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// MiniSys-1A instruction fetch: PC generation, imem req/gnt/rvalid handling, prefetch buffer
// and redirect flushing. Define IFETCH_ADEL_EN to flag unaligned redirect targets.
module ifetch_unit
    import minisys_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] instruction,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    output logic              inst_adel
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   ret_pc_q, ret_pc_d;
    logic [31:0]   adel_pc_q, adel_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] stale_q, stale_d;
    logic          halted_q, halted_d;
    logic          adel_valid_q, adel_valid_d;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic [31:0]   redirect_aligned;
    logic          grant, rsp_live, push, pop_fifo, head_valid, adel_hit;
    fetch_entry_t  push_entry, head_entry;

    assign redirect_aligned = redirect_pc & ~32'h3;

`ifdef IFETCH_ADEL_EN
    assign adel_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign adel_hit = 1'b0;
`endif

    // Every issued request owns a buffer slot until its word is popped or discarded.
    assign in_use     = {1'b0, stale_q} + {1'b0, live_q} + {1'b0, fifo_count};
    assign imem_req   = !rst && !halted_q && (in_use < DEPTH_W);
    assign imem_addr  = fetch_pc_q;
    assign grant      = imem_req && imem_gnt;
    assign rsp_live   = imem_rvalid && (stale_q == '0);
    assign push       = rsp_live && !redirect_valid;
    assign head_valid = fifo_count != '0;
    assign pop_fifo   = inst_ready && head_valid && !adel_valid_q;
    assign push_entry = '{pc: ret_pc_q, instruction: imem_rdata};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop_fifo),
        .flush     (redirect_valid),
        .head      (head_entry),
        .count     (fifo_count)
    );

    always_comb begin
        inst_valid  = 1'b0;
        instruction = NOP_WORD;
        inst_pc     = '0;
        inst_adel   = 1'b0;
        if (adel_valid_q) begin
            inst_valid = 1'b1;
            inst_pc    = adel_pc_q;
            inst_adel  = 1'b1;
        end else if (head_valid) begin
            inst_valid  = 1'b1;
            instruction = head_entry.instruction;
            inst_pc     = head_entry.pc;
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        ret_pc_d     = ret_pc_q;
        adel_pc_d    = adel_pc_q;
        live_d       = live_q;
        stale_d      = stale_q;
        halted_d     = halted_q;
        adel_valid_d = adel_valid_q;

        if (grant) fetch_pc_d = fetch_pc_q + PC_INC;
        if (push) ret_pc_d = ret_pc_q + PC_INC;
        if (adel_valid_q && inst_ready) adel_valid_d = 1'b0;

        if (redirect_valid) begin
            // Everything in flight, including this cycle's grant and response, becomes stale.
            stale_d      = stale_q + live_q + CW'(grant) - CW'(imem_rvalid);
            live_d       = '0;
            fetch_pc_d   = redirect_aligned;
            ret_pc_d     = redirect_aligned;
            halted_d     = adel_hit;
            adel_valid_d = adel_hit;
            adel_pc_d    = redirect_pc;
        end else begin
            live_d  = live_q + CW'(grant) - CW'(rsp_live);
            stale_d = stale_q - CW'(imem_rvalid && !rsp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            ret_pc_q     <= RESET_PC;
            adel_pc_q    <= '0;
            live_q       <= '0;
            stale_q      <= '0;
            halted_q     <= 1'b0;
            adel_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            ret_pc_q     <= ret_pc_d;
            adel_pc_q    <= adel_pc_d;
            live_q       <= live_d;
            stale_q      <= stale_d;
            halted_q     <= halted_d;
            adel_valid_q <= adel_valid_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: in-order memory model with random latency, and a
// queue-based reference of issued/returned/buffered words compared every cycle.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        inst_adel;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat_min = 1;
    int lat_max = 1;
    int first_valid;
    int grants;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        oq[$];   // granted, not yet returned
    logic [31:0] fq[$];   // words the decoder should see, oldest first
    logic [31:0] got[$];
    int          epoch    = 0;
    int          last_due = 0;
    logic [31:0] m_fetch  = RESET_PC;
    logic        halted   = 1'b0;
    logic        adel_pend = 1'b0;
    logic [31:0] adel_pc  = '0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .inst_adel      (inst_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic collect(input int n, input int budget);
        got.delete();
        for (int i = 0; i < budget && got.size() < n; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) got.push_back(inst_pc);
            @(posedge clk);
            #1;
        end
        check_word("collect_count", 32'(got.size()), 32'(n));
    endtask

    task automatic check_stream(input string name, input logic [31:0] base, input int n);
        logic [31:0] act;
        for (int i = 0; i < n; i++) begin
            act = (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
            check_word(name, act, base + 32'(4 * i));
        end
    endtask

    // Memory: returns words in grant order, no earlier than the drawn latency.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (oq.size() > 0 && oq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(oq[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
    end

    // Reference model and per-cycle compare; transitions describe the coming clock edge.
    always @(negedge clk) begin
        logic exp_req;
        logic exp_valid;
        req_t e;
        int   lat;
        if (rst) begin
            check_bit("req_in_reset", imem_req, 1'b0);
            oq.delete();
            fq.delete();
            epoch     = 0;
            last_due  = 0;
            m_fetch   = RESET_PC;
            halted    = 1'b0;
            adel_pend = 1'b0;
        end else begin
            exp_req = !halted && ((oq.size() + fq.size()) < DEPTH);
            check_bit("imem_req", imem_req, exp_req);
            if (imem_req) check_word("imem_addr", imem_addr, m_fetch);
            exp_valid = adel_pend || (fq.size() > 0);
            check_bit("inst_valid", inst_valid, exp_valid);
            if (adel_pend) begin
                check_word("adel_pc", inst_pc, adel_pc);
                check_word("adel_instruction", instruction, 32'h0);
                check_bit("adel_flag", inst_adel, 1'b1);
            end else if (fq.size() > 0) begin
                check_word("inst_pc", inst_pc, fq[0]);
                check_word("instruction", instruction, mem_word(fq[0]));
                check_bit("inst_adel", inst_adel, 1'b0);
            end else begin
                check_word("idle_instruction", instruction, 32'h0);
            end

            if (inst_valid && inst_ready) begin
                if (adel_pend) adel_pend = 1'b0;
                else if (fq.size() > 0) void'(fq.pop_front());
            end
            if (imem_rvalid && oq.size() > 0) begin
                e = oq.pop_front();
                if (e.epoch == epoch && !redirect_valid) fq.push_back(e.addr);
            end
            if (imem_req && imem_gnt) begin
                lat = int'($urandom_range(lat_max, lat_min));
                e.addr  = imem_addr;
                e.epoch = epoch;
                e.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = e.due;
                oq.push_back(e);
                m_fetch = m_fetch + 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                fq.delete();
                adel_pend = 1'b0;
                halted    = 1'b0;
                m_fetch   = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_ADEL_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    halted    = 1'b1;
                    adel_pend = 1'b1;
                    adel_pc   = redirect_pc;
                end
`endif
            end
        end
    end

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("rst_imem_req", imem_req, 1'b0);
        check_word("rst_imem_addr", imem_addr, RESET_PC);
        check_bit("rst_inst_valid", inst_valid, 1'b0);
        check_word("rst_instruction", instruction, 32'h0);
        check_word("rst_inst_pc", inst_pc, 32'h0);
        check_bit("rst_inst_adel", inst_adel, 1'b0);

        // Streaming from reset, 1-cycle memory.
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        got.delete();
        first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_bit("first_req", imem_req, 1'b1);
                check_word("first_addr", imem_addr, RESET_PC);
            end
            if (inst_valid && first_valid < 0) first_valid = c;
            if (inst_valid && inst_ready) got.push_back(inst_pc);
            @(posedge clk);
            #1;
        end
        check_word("first_valid_cycle", 32'(first_valid), 32'd2);
        check_stream("seq_from_reset", RESET_PC, 4);

        // Decoder stall: the new stream may only get DEPTH requests in flight/buffered.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        grants = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) grants++;
            if (c == 10) check_bit("stall_req_low", imem_req, 1'b0);
            @(posedge clk);
            #1;
        end
        check_word("stall_grants", 32'(grants), DEPTH);
        inst_ready = 1'b1;
        collect(8, 40);
        check_stream("stall_resume", 32'h0000_0400, 8);

        // Redirect with several requests outstanding on a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check_bit("pre_flush_valid", inst_valid, 1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_bit("flushed_same_edge", inst_valid, 1'b0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        collect(3, 40);
        check_stream("after_redirect", 32'h0000_0100, 3);

        // Redirect on a cycle with both a grant and a response, into the address wrap.
        lat_min = 1;
        lat_max = 1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        check_bit("coincide_grant", imem_req && imem_gnt, 1'b1);
        check_bit("coincide_rvalid", imem_rvalid, 1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        collect(3, 20);
        check_stream("wrap", 32'hFFFF_FFF8, 3);

`ifdef IFETCH_ADEL_EN
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_bit("adel_valid", inst_valid, 1'b1);
        check_bit("adel_set", inst_adel, 1'b1);
        check_word("adel_word", instruction, 32'h0);
        check_word("adel_inst_pc", inst_pc, 32'h0000_0102);
        check_bit("adel_halt", imem_req, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_bit("adel_still_halted", imem_req, 1'b0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("adel_popped", inst_valid, 1'b0);
        check_bit("adel_halt_after_pop", imem_req, 1'b0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_bit("adel_resume_req", imem_req, 1'b1);
        check_word("adel_resume_addr", imem_addr, 32'h0000_0200);
        @(posedge clk);
        #1;
`endif

        // Random traffic with a mid-run reset.
        lat_min = 1;
        lat_max = 4;
        for (int c = 0; c < 2500; c++) begin
            imem_gnt       = ($urandom_range(9, 0) < 7);
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = 1'b0;
            if (c == 1200 || c == 1201) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
                if ($urandom_range(99, 0) < 3) begin
                    redirect_valid = 1'b1;
                    case ($urandom_range(3, 0))
                        0:       redirect_pc = $urandom;
                        1:       redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(3, 0) << 2);
                        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
                    endcase
                end
            end
            @(posedge clk);
            #1;
        end

        redirect_valid = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("final_rst_req", imem_req, 1'b0);
        check_bit("final_rst_valid", inst_valid, 1'b0);
        check_word("final_rst_instruction", instruction, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
